// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    WAIT  = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_sel(input logic [1:0] d);
    an_sel = ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running prescaler; tick is high for one cycle every REFRESH_DIV cycles.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Holds the last two received bytes as four hex digits and scans them onto a
// multiplexed display, fetching each digit's pattern from an external 1-cycle ROM.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clr,
  output logic [3:0] rom_add,
  input  logic [7:0] rom_data,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic tick;

  refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  scan_state_e                      state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]       hist_q, hist_d;
  logic [1:0]                       fill_q, fill_d;
  logic [1:0]                       digit_q, digit_d;
  logic [3:0]                       rom_add_q, rom_add_d;
  logic                             lit_q, lit_d;
  logic                             populated;
  logic                             show_on;

  // Upper two digits only come from the older byte, so they need both bytes.
  assign populated = digit_q[1] ? (fill_q == 2'd2) : (fill_q != 2'd0);

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    digit_d   = digit_q;
    rom_add_d = rom_add_q;
    lit_d     = lit_q;

    if (clr) begin
      hist_d = '0;
      fill_d = 2'd0;
    end else if (rx_valid) begin
      hist_d = {hist_q[1:0], rx_data};
      fill_d = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
    end

    // Nibble and populated flag are snapshotted at fetch so mid-slot updates
    // or clears never disturb the digit currently being shown.
    case (state_q)
      BLANK: begin
        rom_add_d = hist_q[digit_q];
        lit_d     = populated;
        state_d   = WAIT;
      end
      WAIT:  state_d = SHOW;
      SHOW: begin
        if (tick) begin
          digit_d = digit_q + 2'd1;
          state_d = BLANK;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      hist_q    <= '0;
      fill_q    <= 2'd0;
      digit_q   <= 2'd0;
      rom_add_q <= 4'd0;
      lit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      digit_q   <= digit_d;
      rom_add_q <= rom_add_d;
      lit_q     <= lit_d;
    end
  end

  // Drive decodes straight from registered state: lit for the whole SHOW
  // state, and dark the instant reset clears the state register.
  assign show_on = (state_q == SHOW) && lit_q;
  assign rom_add = rom_add_q;
  assign an      = show_on ? an_sel(digit_q) : AN_OFF;
  assign seg     = show_on ? rom_data : SEG_OFF;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: per-slot expectations are queued from a
// behavioural model and compared against every cycle of the observed slot.
module tb_seven_seg_scan;

  localparam int DIV = 8;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] add;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] rom_add;
  logic [7:0] rom_data;
  logic [7:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  slot_t       exp_q[$];
  logic [15:0] m_hist;
  int          m_fill;

  seven_seg_scan #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .clr      (clr),
    .rom_add  (rom_add),
    .rom_data (rom_data),
    .seg      (seg),
    .an       (an)
  );

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= hex7(rom_add);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && !$onehot0(~an)) begin
      bad++;
      $display("FAIL onehot_an: an=%b required at most one low bit", an);
    end

  function automatic slot_t model_slot(input int d);
    logic [3:0] nib;
    logic [3:0] one;
    logic       pop;
    slot_t      r;
    one   = 4'b0001;
    nib   = m_hist[4*d +: 4];
    pop   = (d < 2) ? (m_fill >= 1) : (m_fill == 2);
    r.add = nib;
    r.an  = pop ? ~(one << d) : 4'hF;
    r.seg = pop ? hex7(nib) : 8'hFF;
    return r;
  endfunction

  task automatic model_rx(input logic [7:0] d);
    m_hist = {m_hist[7:0], d};
    if (m_fill < 2) m_fill++;
  endtask

  task automatic push_slots(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model_slot((first + i) % 4));
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cyc % DIV) != p && k < 20);
    if ((cyc % DIV) != p) begin
      total++; bad++;
      $display("FAIL wait_phase: phase=%0d required %0d", cyc % DIV, p);
    end
  endtask

  task automatic wait_cyc(input int t);
    int k = 0;
    while (cyc != t && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (cyc != t) begin
      total++; bad++;
      $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, t);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic c);
    rx_data = d; rx_valid = 1'b1; clr = c;
    @(negedge clk);
    rx_valid = 1'b0; clr = 1'b0;
  endtask

  // Observe n whole slots; optionally drive rx/clr at one phase of one slot.
  task automatic run_slots(input int n, input int inj_slot, input int inj_phase,
                           input logic inj_rx, input logic [7:0] inj_data, input logic inj_clr);
    for (int s = 0; s < n; s++) begin
      slot_t      e;
      int         lit;
      logic       off_bad, on_bad;
      logic [3:0] bad_an, add_seen;
      logic [7:0] bad_seg;
      wait_phase(0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: slot %0d has no expectation", s);
        continue;
      end
      e = exp_q.pop_front();
      lit = 0; off_bad = 1'b0; on_bad = 1'b0;
      bad_an = an; bad_seg = seg; add_seen = 4'h0;
      for (int p = 0; p < DIV; p++) begin
        if (p > 0) @(negedge clk);
        if (an != 4'hF) lit++;
        if (p < 2) begin
          if ((an !== 4'hF || seg !== 8'hFF) && !off_bad) begin
            off_bad = 1'b1; bad_an = an; bad_seg = seg;
          end
        end else if ((an !== e.an || seg !== e.seg) && !on_bad) begin
          on_bad = 1'b1; bad_an = an; bad_seg = seg;
        end
        if (p == 4) add_seen = rom_add;
        rx_valid = 1'b0; clr = 1'b0;
        if (s == inj_slot && p == inj_phase) begin
          rx_valid = inj_rx; rx_data = inj_data; clr = inj_clr;
        end
      end
      rx_valid = 1'b0; clr = 1'b0;
      total++;
      if (off_bad) begin
        bad++;
        $display("FAIL slot_gap: an=%b seg=%h required an=1111 seg=ff", bad_an, bad_seg);
      end
      total++;
      if (on_bad) begin
        bad++;
        $display("FAIL slot_show: an=%b seg=%h required an=%b seg=%h", bad_an, bad_seg, e.an, e.seg);
      end
      total++;
      if (add_seen !== e.add) begin
        bad++;
        $display("FAIL slot_rom_add: got %h required %h", add_seen, e.add);
      end
      total++;
      if (lit != ((e.an != 4'hF) ? DIV - 2 : 0)) begin
        bad++;
        $display("FAIL slot_lit_cycles: got %0d required %0d", lit, (e.an != 4'hF) ? DIV - 2 : 0);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_hist = 16'h0000; m_fill = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (an !== 4'hF) begin bad++; $display("FAIL reset_an: got %b required 1111", an); end
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h required ff", seg); end
    total++;
    if (rom_add !== 4'h0) begin bad++; $display("FAIL reset_rom_add: got %h required 0", rom_add); end
    do_reset();
    push_slots(1, 8);
    run_slots(8, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_single_byte();
    do_reset();
    wait_phase(3);
    send_byte(8'h3A, 1'b0);
    model_rx(8'h3A);
    push_slots(cyc / DIV + 1, 4);
    run_slots(4, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_two_bytes();
    do_reset();
    wait_phase(2);
    send_byte(8'h3A, 1'b0);
    send_byte(8'h5C, 1'b0);
    model_rx(8'h3A);
    model_rx(8'h5C);
    push_slots(1, 8);
    run_slots(8, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_clr_same_cycle();
    do_reset();
    wait_phase(2);
    send_byte(8'h12, 1'b0);
    send_byte(8'h77, 1'b1);
    m_hist = 16'h0000; m_fill = 0;
    push_slots(1, 4);
    run_slots(4, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_clr_mid_show();
    do_reset();
    wait_phase(2);
    send_byte(8'h3A, 1'b0);
    model_rx(8'h3A);
    push_slots(1, 4);
    run_slots(4, 3, 3, 1'b0, 8'h00, 1'b1);
    m_hist = 16'h0000; m_fill = 0;
    push_slots(5, 4);
    run_slots(4, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    wait_phase(2);
    send_byte(8'h3A, 1'b0);
    wait_cyc(4 * DIV + 4);
    total++;
    if (an !== 4'b1110) begin bad++; $display("FAIL pre_reset_lit: an=%b required 1110", an); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (an !== 4'hF) begin bad++; $display("FAIL async_reset_an: got %b required 1111", an); end
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL async_reset_seg: got %h required ff", seg); end
    total++;
    if (rom_add !== 4'h0) begin bad++; $display("FAIL async_reset_rom_add: got %h required 0", rom_add); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_hist = 16'h0000; m_fill = 0;
    exp_q.delete();
    wait_phase(3);
    send_byte(8'h3A, 1'b0);
    model_rx(8'h3A);
    push_slots(1, 4);
    run_slots(4, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_update_in_show();
    do_reset();
    wait_phase(2);
    send_byte(8'h3A, 1'b0);
    model_rx(8'h3A);
    push_slots(1, 4);
    run_slots(4, 3, 3, 1'b1, 8'h12, 1'b0);
    model_rx(8'h12);
    push_slots(5, 4);
    run_slots(4, -1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    m_hist = 16'h0000;
    m_fill = 0;
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_clr_same_cycle();
    test_clr_mid_show();
    test_reset_mid_show();
    test_update_in_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
